// File: rtl/gen_scheduler.sv
// gen_scheduler: paces the life engine against the display.
// Divides render frames down to a generation rate and issues logic start
// pulses. Swaps buffers only at frame end, and gives up on a generation
// the life logic never finishes.
//
// Ports:
//   clk_in, rst_n_in    clock, asynchronous active-low reset
//   speed_in            speed setting, larger = faster (frame divider reload)
//   run_in              level, 1 = free run, 0 = paused
//   step_in             pulse, advance one generation while paused
//   render_done_in      pulse, end of a rendered frame
//   logic_done_in       pulse, life logic finished a generation
//   buf_ready_in        level, double buffer can accept a swap
//   logic_start_out     pulse, start next generation
//   buf_swap_out        pulse, swap buffers
//   busy_out            high whenever the scheduler is not idle
//   gen_count_out       completed (swapped) generations, wraps
//   timeout_out         sticky watchdog flag
module gen_scheduler #(
    parameter int unsigned SPEED_WIDTH    = 4,
    parameter int unsigned TIMEOUT_CYCLES = 2000000,
    parameter int unsigned GEN_WIDTH      = 16
) (
    input  logic                   clk_in,
    input  logic                   rst_n_in,
    input  logic [SPEED_WIDTH-1:0] speed_in,
    input  logic                   run_in,
    input  logic                   step_in,
    input  logic                   render_done_in,
    input  logic                   logic_done_in,
    input  logic                   buf_ready_in,
    output logic                   logic_start_out,
    output logic                   buf_swap_out,
    output logic                   busy_out,
    output logic [GEN_WIDTH-1:0]   gen_count_out,
    output logic                   timeout_out
);

    localparam int unsigned WD_WIDTH = $clog2(TIMEOUT_CYCLES);
    localparam logic [SPEED_WIDTH-1:0] FRAME_MAX = '1;
    localparam logic [WD_WIDTH-1:0]    WD_LAST   = WD_WIDTH'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        COMPUTE   = 3'd2,
        WAIT_SWAP = 3'd3,
        SWAP      = 3'd4
    } state_t;

    state_t                 state, state_nxt;
    logic [SPEED_WIDTH-1:0] frame_cnt, frame_nxt;
    logic [WD_WIDTH-1:0]    wd_cnt, wd_nxt;
    logic [GEN_WIDTH-1:0]   gen_nxt;
    logic                   timeout_nxt;

    // State, counters and registered outputs; pulses are decoded from the
    // next state so they line up with the state they belong to.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state           <= IDLE;
            frame_cnt       <= FRAME_MAX;
            wd_cnt          <= '0;
            logic_start_out <= 1'b0;
            buf_swap_out    <= 1'b0;
            busy_out        <= 1'b0;
            gen_count_out   <= '0;
            timeout_out     <= 1'b0;
        end else begin
            state           <= state_nxt;
            frame_cnt       <= frame_nxt;
            wd_cnt          <= wd_nxt;
            logic_start_out <= (state_nxt == START);
            buf_swap_out    <= (state_nxt == SWAP);
            busy_out        <= (state_nxt != IDLE);
            gen_count_out   <= gen_nxt;
            timeout_out     <= timeout_nxt;
        end
    end

    // Next-state and counter updates.
    always_comb begin
        state_nxt   = state;
        frame_nxt   = frame_cnt;
        wd_nxt      = wd_cnt;
        gen_nxt     = gen_count_out;
        timeout_nxt = timeout_out;
        case (state)
            IDLE: begin
                // Divider only counts frames that pass while idle.
                if (render_done_in && (frame_cnt != '0)) begin
                    frame_nxt = frame_cnt - SPEED_WIDTH'(1);
                end
                if ((run_in && (frame_cnt == '0)) || (!run_in && step_in)) begin
                    state_nxt = START;
                end
            end
            START: begin
                frame_nxt = FRAME_MAX - speed_in;
                wd_nxt    = '0;
                state_nxt = COMPUTE;
            end
            COMPUTE: begin
                // A done arriving on the expiry cycle still counts.
                if (logic_done_in) begin
                    state_nxt = WAIT_SWAP;
                end else if (wd_cnt == WD_LAST) begin
                    timeout_nxt = 1'b1;
                    state_nxt   = IDLE;
                end else begin
                    wd_nxt = wd_cnt + WD_WIDTH'(1);
                end
            end
            WAIT_SWAP: begin
                if (render_done_in && buf_ready_in) begin
                    gen_nxt   = gen_count_out + GEN_WIDTH'(1);
                    state_nxt = SWAP;
                end
            end
            SWAP: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_gen_scheduler.sv
// Testbench for gen_scheduler: scripted stimulus at known cycles, expected
// start/swap pulses queued with their cycle and generation count, and a
// negedge monitor that pops and compares every pulse the DUT emits.
module tb_gen_scheduler;

    localparam int unsigned SW = 4;
    localparam int unsigned TO = 50;
    localparam int unsigned GW = 16;

    logic          clk_in = 1'b0;
    logic          rst_n_in;
    logic [SW-1:0] speed_in;
    logic          run_in, step_in, render_done_in, logic_done_in, buf_ready_in;
    logic          logic_start_out, buf_swap_out, busy_out, timeout_out;
    logic [GW-1:0] gen_count_out;

    gen_scheduler #(
        .SPEED_WIDTH    (SW),
        .TIMEOUT_CYCLES (TO),
        .GEN_WIDTH      (GW)
    ) dut (
        .clk_in          (clk_in),
        .rst_n_in        (rst_n_in),
        .speed_in        (speed_in),
        .run_in          (run_in),
        .step_in         (step_in),
        .render_done_in  (render_done_in),
        .logic_done_in   (logic_done_in),
        .buf_ready_in    (buf_ready_in),
        .logic_start_out (logic_start_out),
        .buf_swap_out    (buf_swap_out),
        .busy_out        (busy_out),
        .gen_count_out   (gen_count_out),
        .timeout_out     (timeout_out)
    );

    always #5 clk_in = ~clk_in;

    int cyc = 0;
    always @(posedge clk_in) cyc <= cyc + 1;

    typedef struct {
        int kind;   // 0 = logic_start, 1 = buf_swap
        int cyc;
        int gen;
    } ev_t;

    ev_t exp_q[$];
    ev_t mon_e;
    int  mon_kind;
    int  checks = 0;
    int  errors = 0;

    task automatic expect_ev(input int kind, input int c, input int gen);
        ev_t e;
        e.kind = kind;
        e.cyc  = c;
        e.gen  = gen;
        exp_q.push_back(e);
    endtask

    // Scoreboard: every emitted pulse must match the head of the queue.
    always @(negedge clk_in) begin
        if (logic_start_out || buf_swap_out) begin
            mon_kind = buf_swap_out ? 1 : 0;
            checks++;
            if (logic_start_out && buf_swap_out) begin
                errors++;
                $display("FAIL pulse_overlap cyc=%0d start=1 swap=1 required at most one", cyc);
            end else if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_pulse kind=%0d cyc=%0d gen=%0d required none",
                         mon_kind, cyc, gen_count_out);
            end else begin
                mon_e = exp_q.pop_front();
                if (mon_e.kind != mon_kind || mon_e.cyc != cyc ||
                    (mon_kind == 1 && gen_count_out !== GW'(mon_e.gen))) begin
                    errors++;
                    $display("FAIL pulse kind=%0d cyc=%0d gen=%0d required kind=%0d cyc=%0d gen=%0d",
                             mon_kind, cyc, gen_count_out, mon_e.kind, mon_e.cyc, mon_e.gen);
                end
            end
        end
    end

    // Advance to 1ns after the posedge that starts cycle c.
    task automatic goto(input int c);
        while (cyc < c) begin
            @(posedge clk_in);
            #1;
        end
    endtask

    task automatic pulse_render(input int c);
        goto(c);
        render_done_in = 1'b1;
        goto(c + 1);
        render_done_in = 1'b0;
    endtask

    task automatic pulse_done(input int c);
        goto(c);
        logic_done_in = 1'b1;
        goto(c + 1);
        logic_done_in = 1'b0;
    endtask

    task automatic pulse_step(input int c);
        goto(c);
        step_in = 1'b1;
        goto(c + 1);
        step_in = 1'b0;
    endtask

    task automatic check_drained(input string name, input int gen);
        checks++;
        if (exp_q.size() != 0 || gen_count_out !== GW'(gen) || busy_out !== 1'b0) begin
            errors++;
            $display("FAIL %s pending=%0d gen=%0d busy=%0b required pending=0 gen=%0d busy=0",
                     name, exp_q.size(), gen_count_out, busy_out, gen);
            exp_q.delete();
        end
    endtask

    task automatic test_reset();
        rst_n_in = 1'b1;
        speed_in = SW'(15);
        run_in = 1'b0; step_in = 1'b0; render_done_in = 1'b0;
        logic_done_in = 1'b0; buf_ready_in = 1'b1;
        #2 rst_n_in = 1'b0;
        #1;
        checks++;
        if ({logic_start_out, buf_swap_out, busy_out, timeout_out} !== 4'b0 || gen_count_out !== '0) begin
            errors++;
            $display("FAIL reset_values start=%0b swap=%0b busy=%0b to=%0b gen=%0d required all 0",
                     logic_start_out, buf_swap_out, busy_out, timeout_out, gen_count_out);
        end
        goto(3);
        rst_n_in = 1'b1;
        goto(6);
        checks++;
        if (busy_out !== 1'b0 || gen_count_out !== '0) begin
            errors++;
            $display("FAIL reset_idle busy=%0b gen=%0d required 0 0", busy_out, gen_count_out);
        end
    endtask

    // speed 15 from reset: divider starts at 15, so 15 idle frames first.
    task automatic test_free_run();
        int b, s;
        b = cyc + 2;
        run_in = 1'b1;
        s = b + 152;                       // last frame at b+150, count 0 at b+151
        expect_ev(0, s, 0);
        expect_ev(1, s + 21, 1);
        for (int k = 1; k <= 15; k++) pulse_render(b + 10 * k);
        goto(s + 5);
        run_in = 1'b0;                     // generation in flight still completes
        pulse_done(s + 10);
        pulse_render(s + 20);
        goto(s + 40);
        check_drained("free_run", 1);
    endtask

    // speed 12 -> reload 3; frames during compute are not counted.
    task automatic test_speed_divider();
        int b, s2;
        b = cyc + 2;
        speed_in = SW'(12);
        goto(b);
        run_in = 1'b1;                     // divider already 0 from speed 15 reload
        expect_ev(0, b + 1, 1);
        expect_ev(1, b + 9, 2);
        pulse_render(b + 3);
        pulse_done(b + 5);
        pulse_render(b + 8);
        pulse_render(b + 15);
        pulse_render(b + 20);
        goto(b + 24);
        checks++;
        if (busy_out !== 1'b0) begin
            errors++;
            $display("FAIL divider_early busy=%0b required 0", busy_out);
        end
        s2 = b + 27;
        expect_ev(0, s2, 2);
        expect_ev(1, s2 + 9, 3);
        pulse_render(b + 25);
        pulse_done(s2 + 3);
        goto(s2 + 4);
        run_in = 1'b0;
        pulse_render(s2 + 8);
        goto(s2 + 25);
        check_drained("speed_divider", 3);
    endtask

    // Paused single-step; extra step in COMPUTE and step while running ignored.
    task automatic test_step();
        int b;
        b = cyc + 2;
        expect_ev(0, b + 1, 3);
        expect_ev(1, b + 13, 4);
        pulse_step(b);
        pulse_step(b + 4);
        pulse_done(b + 8);
        pulse_render(b + 12);
        goto(b + 18);
        run_in = 1'b1;                     // divider reloaded to 3, so no trigger
        pulse_step(b + 20);
        goto(b + 23);
        run_in = 1'b0;
        goto(b + 30);
        check_drained("step", 4);
    endtask

    task automatic test_buf_not_ready();
        int b;
        b = cyc + 2;
        expect_ev(0, b + 1, 4);
        expect_ev(1, b + 15, 5);
        pulse_step(b);
        pulse_done(b + 4);
        buf_ready_in = 1'b0;
        pulse_render(b + 8);
        goto(b + 10);
        buf_ready_in = 1'b1;
        goto(b + 12);
        checks++;
        if (busy_out !== 1'b1 || gen_count_out !== GW'(4)) begin
            errors++;
            $display("FAIL not_ready_wait busy=%0b gen=%0d required 1 4", busy_out, gen_count_out);
        end
        pulse_render(b + 14);
        goto(b + 25);
        check_drained("buf_not_ready", 5);
    endtask

    task automatic test_watchdog();
        int s;
        s = cyc + 3;
        expect_ev(0, s, 5);
        pulse_step(s - 1);
        goto(s + 50);
        checks++;
        if (timeout_out !== 1'b0 || busy_out !== 1'b1) begin
            errors++;
            $display("FAIL watchdog_early to=%0b busy=%0b required 0 1", timeout_out, busy_out);
        end
        goto(s + 51);
        checks++;
        if (timeout_out !== 1'b1 || busy_out !== 1'b0 || gen_count_out !== GW'(5)) begin
            errors++;
            $display("FAIL watchdog_fire to=%0b busy=%0b gen=%0d required 1 0 5",
                     timeout_out, busy_out, gen_count_out);
        end
        pulse_render(s + 55);
        pulse_done(s + 60);
        expect_ev(0, s + 71, 5);
        expect_ev(1, s + 81, 6);
        pulse_step(s + 70);
        pulse_done(s + 75);
        pulse_render(s + 80);
        goto(s + 90);
        check_drained("watchdog", 6);
        checks++;
        if (timeout_out !== 1'b1) begin
            errors++;
            $display("FAIL watchdog_sticky to=%0b required 1", timeout_out);
        end
    endtask

    task automatic test_reset_mid_compute();
        int b;
        b = cyc + 2;
        expect_ev(0, b + 1, 6);
        pulse_step(b);
        goto(b + 5);
        rst_n_in = 1'b0;
        #1;
        checks++;
        if ({logic_start_out, buf_swap_out, busy_out, timeout_out} !== 4'b0 || gen_count_out !== '0) begin
            errors++;
            $display("FAIL async_reset start=%0b swap=%0b busy=%0b to=%0b gen=%0d required all 0",
                     logic_start_out, buf_swap_out, busy_out, timeout_out, gen_count_out);
        end
        goto(b + 8);
        rst_n_in = 1'b1;
        pulse_done(b + 10);
        pulse_render(b + 14);
        goto(b + 25);
        check_drained("reset_mid_compute", 0);
    endtask

    initial begin
        test_reset();
        test_free_run();
        test_speed_divider();
        test_step();
        test_buf_not_ready();
        test_watchdog();
        test_reset_mid_compute();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
